layer2_seq: RTL and testbench

LAYER2_SEQ -- requirements
Module: layer2_seq

---
 rtl/layer2_seq.sv | 193 +++++++++++++++++++
 tb/tb_layer2_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/layer2_seq.sv
// Layer-2 sequencer: streams conv results into the result memory channel by channel, then walks the 2x2 pooling windows.
// Optional stall counter output enabled by defining LAYER2_SEQ_STALL_CNT_EN.
module layer2_seq #(
  parameter int MAP_W  = 14,
  parameter int NUM_OC = 16,
  parameter int MAP_SZ = 196
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              res_valid,
  input  logic signed [7:0] res_data,
  output logic              res_ready,
  output logic              store,
  output logic [3:0]        out_c,
  output logic [7:0]        w_addr,
  output logic signed [7:0] value,
  output logic              pool,
  output logic [7:0]        pool_addr,
  output logic [7:0]        pool_waddr,
  output logic              cout_done,
  output logic              done,
`ifdef LAYER2_SEQ_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              busy
);

  localparam int         POOL_N    = MAP_W / 2;
  localparam logic [2:0] POOL_LAST = 3'(POOL_N - 1);
  localparam logic [7:0] PIX_LAST  = 8'(MAP_SZ - 1);
  localparam logic [3:0] CH_LAST   = 4'(NUM_OC - 1);
  localparam logic [7:0] ROW_STEP  = 8'(2 * MAP_W);
  localparam logic [7:0] WROW_STEP = 8'(POOL_N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    POOL  = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        pix_q, pix_d;
  logic [3:0]        ch_q, ch_d;
  logic [2:0]        pr_q, pr_d;
  logic [2:0]        pc_q, pc_d;
  logic              store_q, store_d;
  logic [3:0]        out_c_q, out_c_d;
  logic [7:0]        w_addr_q, w_addr_d;
  logic signed [7:0] value_q, value_d;
  logic              pool_q, pool_d;
  logic [7:0]        pool_addr_q, pool_addr_d;
  logic [7:0]        pool_waddr_q, pool_waddr_d;
  logic              cout_done_q, cout_done_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pix_q        <= '0;
      ch_q         <= '0;
      pr_q         <= '0;
      pc_q         <= '0;
      store_q      <= 1'b0;
      out_c_q      <= '0;
      w_addr_q     <= '0;
      value_q      <= '0;
      pool_q       <= 1'b0;
      pool_addr_q  <= '0;
      pool_waddr_q <= '0;
      cout_done_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_q        <= pix_d;
      ch_q         <= ch_d;
      pr_q         <= pr_d;
      pc_q         <= pc_d;
      store_q      <= store_d;
      out_c_q      <= out_c_d;
      w_addr_q     <= w_addr_d;
      value_q      <= value_d;
      pool_q       <= pool_d;
      pool_addr_q  <= pool_addr_d;
      pool_waddr_q <= pool_waddr_d;
      cout_done_q  <= cout_done_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pix_d        = pix_q;
    ch_d         = ch_q;
    pr_d         = pr_q;
    pc_d         = pc_q;
    store_d      = 1'b0;
    out_c_d      = out_c_q;
    w_addr_d     = w_addr_q;
    value_d      = value_q;
    pool_d       = 1'b0;
    pool_addr_d  = pool_addr_q;
    pool_waddr_d = pool_waddr_q;
    cout_done_d  = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pix_d   = '0;
          ch_d    = '0;
          pr_d    = '0;
          pc_d    = '0;
          state_d = STORE;
        end
      end
      STORE: begin
        if (res_valid) begin
          store_d  = 1'b1;
          value_d  = res_data;
          w_addr_d = pix_q;
          out_c_d  = ch_q;
          if (pix_q == PIX_LAST) begin
            pix_d = '0;
            // cout_done rides with the final store so the memory side sees both together
            if (ch_q == CH_LAST) begin
              ch_d        = '0;
              cout_done_d = 1'b1;
              state_d     = POOL;
            end else begin
              ch_d = ch_q + 4'd1;
            end
          end else begin
            pix_d = pix_q + 8'd1;
          end
        end
      end
      POOL: begin
        pool_d       = 1'b1;
        pool_addr_d  = ROW_STEP * {5'd0, pr_q} + {4'd0, pc_q, 1'b0};
        pool_waddr_d = WROW_STEP * {5'd0, pr_q} + {5'd0, pc_q};
        if (pc_q == POOL_LAST) begin
          pc_d = '0;
          if (pr_q == POOL_LAST) begin
            pr_d    = '0;
            state_d = FIN;
          end else begin
            pr_d = pr_q + 3'd1;
          end
        end else begin
          pc_d = pc_q + 3'd1;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef LAYER2_SEQ_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start)
      stall_d = '0;
    else if (state_q == STORE && !res_valid && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

  assign res_ready  = (state_q == STORE);
  assign busy       = (state_q != IDLE);
  assign store      = store_q;
  assign out_c      = out_c_q;
  assign w_addr     = w_addr_q;
  assign value      = value_q;
  assign pool       = pool_q;
  assign pool_addr  = pool_addr_q;
  assign pool_waddr = pool_waddr_q;
  assign cout_done  = cout_done_q;
  assign done       = done_q;

endmodule

// File: tb/tb_layer2_seq.sv
// Randomized bench for layer2_seq against a pass-level model (flat accept index, post-store cycle count).
// Stall counter checks are compiled in when LAYER2_SEQ_STALL_CNT_EN is defined.
module tb_layer2_seq;

  localparam int MAP_W  = 14;
  localparam int NUM_OC = 16;
  localparam int MAP_SZ = 196;
  localparam int TOTAL  = MAP_SZ * NUM_OC;
  localparam int NWIN   = (MAP_W / 2) * (MAP_W / 2);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              res_valid = 1'b0;
  logic signed [7:0] res_data = '0;
  logic              res_ready, store, pool, cout_done, done, busy;
  logic [3:0]        out_c;
  logic [7:0]        w_addr, pool_addr, pool_waddr;
  logic signed [7:0] value;
`ifdef LAYER2_SEQ_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  layer2_seq #(.MAP_W(MAP_W), .NUM_OC(NUM_OC), .MAP_SZ(MAP_SZ)) dut (
    .clk(clk), .rst(rst), .start(start), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready), .store(store), .out_c(out_c), .w_addr(w_addr), .value(value),
    .pool(pool), .pool_addr(pool_addr), .pool_waddr(pool_waddr),
    .cout_done(cout_done), .done(done),
`ifdef LAYER2_SEQ_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Pass-level model: busy flag, accepts taken so far, edges since the final accept (-1 = none yet)
  bit busy_m = 1'b0;
  int acc_n  = 0;
  int q_m    = -1;
  int stall_m = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero();
    chk("rst_store", {15'd0, store}, 16'd0);
    chk("rst_out_c", {12'd0, out_c}, 16'd0);
    chk("rst_w_addr", {8'd0, w_addr}, 16'd0);
    chk("rst_value", {8'd0, value}, 16'd0);
    chk("rst_pool", {15'd0, pool}, 16'd0);
    chk("rst_pool_addr", {8'd0, pool_addr}, 16'd0);
    chk("rst_pool_waddr", {8'd0, pool_waddr}, 16'd0);
    chk("rst_cout_done", {15'd0, cout_done}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_res_ready", {15'd0, res_ready}, 16'd0);
`ifdef LAYER2_SEQ_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 16'd0);
`endif
  endtask

  // Called #1 after a rising edge; drives one cycle of inputs and checks what the next edge produces.
  task automatic step(input bit v, input logic signed [7:0] d, input bit st);
    bit in_store, acc_now;
    int acc_prev, w;
    res_valid = v;
    res_data  = d;
    start     = st;
    #1;
    in_store = busy_m && (acc_n < TOTAL);
    chk("res_ready", {15'd0, res_ready}, {15'd0, in_store});
    acc_prev = acc_n;
    acc_now  = in_store && v;
    if (!busy_m && st) begin
      busy_m  = 1'b1;
      acc_n   = 0;
      q_m     = -1;
      stall_m = 0;
    end else begin
      if (in_store && !v && stall_m < 65535) stall_m++;
      if (q_m >= 0) q_m++;
      if (acc_now) begin
        acc_n++;
        if (acc_n == TOTAL) q_m = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("store", {15'd0, store}, {15'd0, acc_now});
    if (acc_now) begin
      chk("w_addr", {8'd0, w_addr}, 16'(acc_prev % MAP_SZ));
      chk("out_c", {12'd0, out_c}, 16'(acc_prev / MAP_SZ));
      chk("value", {8'd0, value}, {8'd0, d});
    end
    chk("cout_done", {15'd0, cout_done}, {15'd0, (acc_now && acc_prev == TOTAL - 1)});
    chk("pool", {15'd0, pool}, {15'd0, (q_m >= 1 && q_m <= NWIN)});
    if (q_m >= 1 && q_m <= NWIN) begin
      w = q_m - 1;
      chk("pool_addr", {8'd0, pool_addr}, 16'(2 * MAP_W * (w / 7) + 2 * (w % 7)));
      chk("pool_waddr", {8'd0, pool_waddr}, 16'(w));
    end
    chk("done", {15'd0, done}, {15'd0, (q_m == NWIN + 1)});
    if (q_m == NWIN + 1) begin
      busy_m = 1'b0;
      q_m    = -1;
    end
    chk("busy", {15'd0, busy}, {15'd0, busy_m});
`ifdef LAYER2_SEQ_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 16'(stall_m));
`endif
  endtask

  task automatic timeout_fail(input string tag);
    n_vec++;
    n_err++;
    $error("FAIL %s observed=timeout expected=pass_complete", tag);
  endtask

  initial begin
    int guard;
    bit tog;
    // Reset state, asynchronous before any clock edge
    #3;
    chk_zero();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Pass A: res_valid in IDLE ignored, then continuous stream with data = index mod 128
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0);
    step(1'b0, 8'd0, 1'b1);
    guard = 0;
    while (busy_m && guard < 5000) begin
      step(1'b1, 8'(acc_n % 128), 1'b0);
      guard++;
    end
    if (busy_m) timeout_fail("passA");
    step(1'b0, 8'd0, 1'b0);

    // Pass B: res_valid every other cycle, start held mid-STORE and through POOL/FIN
    step(1'b0, 8'd0, 1'b1);
    tog = 1'b1;
    guard = 0;
    while (busy_m && guard < 10000) begin
      step(tog, 8'($urandom), (acc_n > 500 && acc_n < 520) || q_m >= 0);
      tog = ~tog;
      guard++;
    end
    if (busy_m) timeout_fail("passB");
`ifdef LAYER2_SEQ_STALL_CNT_EN
    chk("stall_total", stall_cnt, 16'd3135);
`endif

    // Pass C: random valid, abort with async reset at channel 5 pixel 100
    step(1'b0, 8'd0, 1'b1);
    guard = 0;
    while (acc_n < 5 * MAP_SZ + 100 && guard < 10000) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0);
      guard++;
    end
    if (acc_n < 5 * MAP_SZ + 100) timeout_fail("passC_reach");
    res_valid = 1'b1;
    rst = 1'b0;
    #1;
    chk_zero();
    busy_m = 1'b0; acc_n = 0; q_m = -1; stall_m = 0;
    @(posedge clk); #1;
    chk_zero();
    rst = 1'b1;

    // Pass D: fresh pass after abort, starts from channel 0 pixel 0
    step(1'b1, 8'($urandom), 1'b1);
    guard = 0;
    while (busy_m && guard < 10000) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0);
      guard++;
    end
    if (busy_m) timeout_fail("passD");
    step(1'b0, 8'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
